// File: rtl/tournament_update_sequencer_pkg.sv
// Shared types for the tournament predictor update sequencer.
// Build option: TOURN_SPEC_HIST_EN selects speculative path history.
package tourn_pkg;

    localparam int PH_W      = 12;
    localparam int PC_IDX_W  = 10;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        UPD_GLOBAL = 2'd0,
        UPD_LOCAL  = 2'd1,
        UPD_CHOICE = 2'd2
    } upd_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        UPD_G,
        UPD_L,
        UPD_C
    } seq_state_e;

    typedef struct packed {
        logic [PC_IDX_W-1:0] pc_idx;
        logic [PH_W-1:0]     ph_snapshot;
        logic                gp;
        logic                lp;
        logic                pred;
    } inflight_t;

    // Local table writes share the global-width index bus.
    function automatic logic [PH_W-1:0] pc_to_idx(
        input logic [PC_IDX_W-1:0] pc
    );
        return {{(PH_W-PC_IDX_W){1'b0}}, pc};
    endfunction

endpackage

// File: rtl/tournament_update_sequencer_if.sv
// Predict/resolve/update bundle between the predictor tables,
// the pipeline and the sequencer.
interface tournament_update_sequencer_if;
    import tourn_pkg::*;

    logic                pred_valid;
    logic [PC_IDX_W-1:0] pred_pc_idx;
    logic                pred_ready;
    logic [PH_W-1:0]     gp_idx;
    logic [PC_IDX_W-1:0] lp_idx;
    logic                gp_result;
    logic                lp_result;
    logic                choice_result;
    logic                pred_taken;
    logic                res_valid;
    logic                res_taken;
    logic                res_ready;
    logic                mispredict;
    logic                upd_valid;
    logic [1:0]          upd_sel;
    logic [PH_W-1:0]     upd_idx;
    logic                upd_taken;

    modport master (
        output pred_valid, pred_pc_idx, gp_result, lp_result,
        output choice_result, res_valid, res_taken,
        input  pred_ready, gp_idx, lp_idx, pred_taken,
        input  res_ready, mispredict,
        input  upd_valid, upd_sel, upd_idx, upd_taken
    );

    modport slave (
        input  pred_valid, pred_pc_idx, gp_result, lp_result,
        input  choice_result, res_valid, res_taken,
        output pred_ready, gp_idx, lp_idx, pred_taken,
        output res_ready, mispredict,
        output upd_valid, upd_sel, upd_idx, upd_taken
    );

endinterface

// File: rtl/tournament_update_sequencer_fifo.sv
// In-order queue of in-flight predictions awaiting resolution.
// Flush empties the queue and wins over push/pop.
module tourn_inflight_fifo
    import tourn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic      i_clock,
    input  logic      i_reset,
    input  logic      i_push,
    input  inflight_t i_data,
    input  logic      i_pop,
    input  logic      i_flush,
    output inflight_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    inflight_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy guards every read.
    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/tournament_update_sequencer.sv
// Tournament predictor controller: path history, in-flight queue,
// final pick, and the G->L->C table update sequence.
// Build option: TOURN_SPEC_HIST_EN (speculative history + flush).
module tournament_update_sequencer
    import tourn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input logic                         i_clock,
    input logic                         i_reset,
    tournament_update_sequencer_if.slave bus
);

    logic                w_full;
    logic                w_empty;
    logic                w_pred_taken;
    logic                w_pred_fire;
    logic                w_res_fire;
    logic                w_mispredict;
    logic                w_flush;
    inflight_t           w_head;
    inflight_t           w_push_data;
    logic [PH_W-1:0]     r_ph;
    seq_state_e          r_state;
    seq_state_e          w_state_nxt;
    logic [PH_W-1:0]     r_snap;
    logic [PC_IDX_W-1:0] r_pc;
    logic                r_gp;
    logic                r_lp;
    logic                r_actual;
    logic                w_upd_valid;
    upd_sel_e            w_upd_sel;
    logic [PH_W-1:0]     w_upd_idx;
    logic                w_upd_taken;

    assign w_pred_taken   = bus.choice_result ? bus.gp_result
                                              : bus.lp_result;
    assign bus.pred_taken = w_pred_taken;
    assign bus.gp_idx     = r_ph;
    assign bus.lp_idx     = bus.pred_pc_idx;

    assign bus.res_ready  = ~w_empty & (r_state == IDLE);
    assign w_res_fire     = bus.res_valid & bus.res_ready;
    assign w_mispredict   = w_res_fire & (w_head.pred != bus.res_taken);
    assign bus.mispredict = w_mispredict;

`ifdef TOURN_SPEC_HIST_EN
    // Every younger entry was fetched down the wrong path.
    assign w_flush = w_mispredict;
`else
    assign w_flush = 1'b0;
`endif

    assign bus.pred_ready = ~w_full & ~w_flush;
    assign w_pred_fire    = bus.pred_valid & bus.pred_ready;

    assign w_push_data = '{
        pc_idx:      bus.pred_pc_idx,
        ph_snapshot: r_ph,
        gp:          bus.gp_result,
        lp:          bus.lp_result,
        pred:        w_pred_taken
    };

    tourn_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_pred_fire),
        .i_data  (w_push_data),
        .i_pop   (w_res_fire),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Path history: repair from snapshot on mispredict, else shift.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ph <= '0;
`ifdef TOURN_SPEC_HIST_EN
        end else if (w_flush) begin
            r_ph <= {w_head.ph_snapshot[PH_W-2:0], bus.res_taken};
        end else if (w_pred_fire) begin
            r_ph <= {r_ph[PH_W-2:0], w_pred_taken};
`else
        end else if (w_res_fire) begin
            r_ph <= {r_ph[PH_W-2:0], bus.res_taken};
`endif
        end
    end

    // Capture the resolved entry for the update sequence.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_snap   <= '0;
            r_pc     <= '0;
            r_gp     <= 1'b0;
            r_lp     <= 1'b0;
            r_actual <= 1'b0;
        end else if (w_res_fire) begin
            r_snap   <= w_head.ph_snapshot;
            r_pc     <= w_head.pc_idx;
            r_gp     <= w_head.gp;
            r_lp     <= w_head.lp;
            r_actual <= bus.res_taken;
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and table write port drive.
    always_comb begin
        w_state_nxt = r_state;
        w_upd_valid = 1'b0;
        w_upd_sel   = UPD_GLOBAL;
        w_upd_idx   = '0;
        w_upd_taken = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_res_fire) w_state_nxt = UPD_G;
            end
            UPD_G: begin
                w_state_nxt = UPD_L;
                w_upd_valid = 1'b1;
                w_upd_sel   = UPD_GLOBAL;
                w_upd_idx   = r_snap;
                w_upd_taken = r_actual;
            end
            UPD_L: begin
                w_state_nxt = (r_gp != r_lp) ? UPD_C : IDLE;
                w_upd_valid = 1'b1;
                w_upd_sel   = UPD_LOCAL;
                w_upd_idx   = pc_to_idx(r_pc);
                w_upd_taken = r_actual;
            end
            UPD_C: begin
                w_state_nxt = IDLE;
                w_upd_valid = 1'b1;
                w_upd_sel   = UPD_CHOICE;
                w_upd_idx   = r_snap;
                w_upd_taken = (r_gp == r_actual);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.upd_valid = w_upd_valid;
    assign bus.upd_sel   = w_upd_sel;
    assign bus.upd_idx   = w_upd_idx;
    assign bus.upd_taken = w_upd_taken;

endmodule
